// File: rtl/ram_responder.sv
// RAM side of the cache/RAM 4-word line burst protocol: stores write bursts, returns read bursts after READ_LATENCY.
// Optional write-acknowledge state S_WACK is built when RAM_RESP_WRITE_ACK_EN is defined.
module ram_responder #(
  parameter int WORD_SIZE    = 32,
  parameter int ADDR_SIZE    = 14,
  parameter int READ_LATENCY = 2
) (
  input  logic                 ram_clk,
  input  logic                 ram_Reset,
  input  logic                 ram_aval,
  input  logic                 ram_wr,
  input  logic [ADDR_SIZE-1:0] ram_addr,
  input  logic [WORD_SIZE-1:0] ram_data_in,
  output logic                 ram_ack,
  output logic [WORD_SIZE-1:0] ram_data_out,
  output logic                 busy,
  output logic                 err_overlap
);
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_LAT, S_READ, S_WACK} state_t;

  localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

  logic [WORD_SIZE-1:0] mem [2**ADDR_SIZE];

  state_t               state, state_nx;
  logic [2:0]           beat_ctr, beat_nx;
  logic [3:0]           lat_ctr, lat_nx;
  logic [ADDR_SIZE-1:0] base, base_nx;
  logic [ADDR_SIZE-1:0] beat_addr, wr_addr;
  logic                 wr_en, rd_en, wack_nx;

  // Beat addresses wrap inside the aligned 4-word line.
  assign beat_addr = {base[ADDR_SIZE-1:2], base[1:0] + beat_ctr[1:0]};
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    beat_nx  = beat_ctr;
    lat_nx   = lat_ctr;
    base_nx  = base;
    wr_en    = 1'b0;
    wr_addr  = beat_addr;
    rd_en    = 1'b0;
    wack_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (ram_aval) begin
          base_nx = ram_addr;
          if (ram_wr) begin
            wr_en    = 1'b1;
            wr_addr  = ram_addr;
            beat_nx  = 3'd1;
            state_nx = S_WRITE;
          end else begin
            lat_nx   = LAT_INIT;
            beat_nx  = 3'd0;
            state_nx = (READ_LATENCY == 1) ? S_READ : S_LAT;
          end
        end
      end
      S_WRITE: begin
        if (ram_wr) begin
          wr_en = 1'b1;
          if (beat_ctr == 3'd3) begin
            beat_nx  = 3'd0;
`ifdef RAM_RESP_WRITE_ACK_EN
            state_nx = S_WACK;
            wack_nx  = 1'b1;
`else
            state_nx = S_IDLE;
`endif
          end else begin
            beat_nx = beat_ctr + 3'd1;
          end
        end
      end
      S_LAT: begin
        if (lat_ctr <= 4'd1) begin
          lat_nx   = 4'd0;
          beat_nx  = 3'd0;
          state_nx = S_READ;
        end else begin
          lat_nx = lat_ctr - 4'd1;
        end
      end
      S_READ: begin
        // The fifth pass only retires the burst, so busy covers the last ack cycle.
        if (beat_ctr == 3'd4) begin
          beat_nx  = 3'd0;
          state_nx = S_IDLE;
        end else begin
          rd_en   = 1'b1;
          beat_nx = beat_ctr + 3'd1;
        end
      end
`ifdef RAM_RESP_WRITE_ACK_EN
      S_WACK: state_nx = S_IDLE;
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge ram_clk) begin
    if (ram_Reset) begin
      state        <= S_IDLE;
      beat_ctr     <= 3'd0;
      lat_ctr      <= 4'd0;
      base         <= '0;
      ram_ack      <= 1'b0;
      ram_data_out <= '0;
      err_overlap  <= 1'b0;
    end else begin
      state        <= state_nx;
      beat_ctr     <= beat_nx;
      lat_ctr      <= lat_nx;
      base         <= base_nx;
      ram_ack      <= rd_en | wack_nx;
      ram_data_out <= rd_en ? mem[beat_addr] : '0;
      err_overlap  <= err_overlap | (ram_aval & busy);
    end
  end

  // Array is deliberately not reset; a beat coinciding with reset is dropped.
  always_ff @(posedge ram_clk) begin
    if (wr_en && !ram_Reset) mem[wr_addr] <= ram_data_in;
  end
endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: per-cycle expectation arrays filled from burst rules, plus literal data checks.
`timescale 1ns/1ps
module tb_ram_responder;
  localparam int W = 32, A = 14, RL = 2, MAXC = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, aval, wr, ack, busy, err;
  logic [A-1:0] addr;
  logic [W-1:0] din, dout;
  logic         b_rst, b_aval, b_wr, b_ack, b_busy, b_err;
  logic [A-1:0] b_addr;
  logic [W-1:0] b_din, b_dout;

  ram_responder #(.WORD_SIZE(W), .ADDR_SIZE(A), .READ_LATENCY(RL)) dut (
    .ram_clk(clk), .ram_Reset(rst), .ram_aval(aval), .ram_wr(wr), .ram_addr(addr),
    .ram_data_in(din), .ram_ack(ack), .ram_data_out(dout), .busy(busy), .err_overlap(err));

  ram_responder #(.WORD_SIZE(W), .ADDR_SIZE(A), .READ_LATENCY(1)) dut1 (
    .ram_clk(clk), .ram_Reset(b_rst), .ram_aval(b_aval), .ram_wr(b_wr), .ram_addr(b_addr),
    .ram_data_in(b_din), .ram_ack(b_ack), .ram_data_out(b_dout), .busy(b_busy), .err_overlap(b_err));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs for the cycle following edge c.
  logic         e_ack [MAXC];
  logic         e_busy[MAXC];
  logic         e_err [MAXC];
  logic         e_dchk[MAXC];
  logic [W-1:0] e_dat [MAXC];
  logic [W-1:0] m_mem [2**A];
  bit           m_wr  [2**A];
  logic [W-1:0] wd [4];
  int           wg [4];
  logic [W-1:0] got[$];
  int           checks = 0, errors = 0;
  bit           chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (ack !== e_ack[cyc] || busy !== e_busy[cyc] || err !== e_err[cyc] ||
          ((e_dchk[cyc] || !e_ack[cyc]) && dout !== e_dat[cyc])) begin
        errors++;
        $display("FAIL cycle %0d ack/busy/err/data: got %b/%b/%b/%h want %b/%b/%b/%h", cyc,
                 ack, busy, err, dout, e_ack[cyc], e_busy[cyc], e_err[cyc], e_dat[cyc]);
      end
      if (ack === 1'b1) got.push_back(dout);
    end
  end

  function automatic logic [A-1:0] baddr(input logic [A-1:0] b, input int k);
    logic [1:0] lo;
    lo = b[1:0] + 2'(k);
    return {b[A-1:2], lo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_from(input int r);
    for (int c = r; c < MAXC; c++) begin
      e_ack[c] = 1'b0; e_busy[c] = 1'b0; e_err[c] = 1'b0; e_dchk[c] = 1'b0; e_dat[c] = '0;
    end
  endtask

  task automatic set_err_from(input int e);
    for (int c = e; c < MAXC; c++) e_err[c] = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (e_busy[cyc] && n < 50) begin tick(); n++; end
    if (e_busy[cyc]) begin
      checks++; errors++;
      $display("FAIL wait_idle: still busy at cycle %0d, required idle", cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_from(cyc + 1);
    tick();
    rst = 1'b0;
  endtask

  // Burst of wd[0..3] at line offset a, with wg[k] gap cycles before beat k.
  task automatic do_write(input logic [A-1:0] a);
    int e;
    wait_idle();
    aval = 1'b1; wr = 1'b1; addr = a; din = wd[0];
    e = cyc + 1;
    m_mem[a] = wd[0]; m_wr[a] = 1'b1; e_busy[e] = 1'b1;
    tick();
    aval = 1'b0;
    for (int k = 1; k < 4; k++) begin
      for (int j = 0; j < wg[k]; j++) begin
        wr = 1'b0; din = $urandom; e_busy[cyc + 1] = 1'b1;
        tick();
      end
      wr = 1'b1; din = wd[k]; e = cyc + 1;
      m_mem[baddr(a, k)] = wd[k]; m_wr[baddr(a, k)] = 1'b1;
`ifdef RAM_RESP_WRITE_ACK_EN
      e_busy[e] = 1'b1;
      if (k == 3) begin e_ack[e] = 1'b1; e_dat[e] = '0; e_dchk[e] = 1'b1; end
`else
      e_busy[e] = (k != 3);
`endif
      tick();
    end
    wr = 1'b0;
  endtask

  // ovl / rst_off: edge offset after acceptance for an overlapping aval / a reset (0 = none).
  task automatic do_read(input logic [A-1:0] a, input int ovl, input int rst_off);
    int t;
    wait_idle();
    aval = 1'b1; wr = 1'b0; addr = a;
    t = cyc + 1;
    for (int c = t; c <= t + RL + 3; c++) e_busy[c] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e_ack[t+RL+k]  = 1'b1;
      e_dat[t+RL+k]  = m_mem[baddr(a, k)];
      e_dchk[t+RL+k] = m_wr[baddr(a, k)];
    end
    tick();
    aval = 1'b0;
    for (int off = 1; off <= RL + 4; off++) begin
      if (off == rst_off) begin
        rst = 1'b1;
        clear_from(t + off);
        tick();
        rst = 1'b0;
        return;
      end
      if (off == ovl) begin
        aval = 1'b1; wr = 1'($urandom_range(0, 1)); addr = 14'($urandom);
        set_err_from(t + off);
      end
      tick();
      aval = 1'b0; wr = 1'b0;
    end
  endtask

  task automatic expect_words(input string nm, input logic [W-1:0] w0, w1, w2, w3);
    logic [W-1:0] w [4];
    int n;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    n = got.size();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (n < 4) begin
        errors++;
        $display("FAIL %s word %0d: only %0d words returned, required 4", nm, k, n);
      end else if (got[n-4+k] !== w[k]) begin
        errors++;
        $display("FAIL %s word %0d: got %h required %h", nm, k, got[n-4+k], w[k]);
      end
    end
  endtask

  task automatic expect_count(input string nm, input int n0, input int want);
    checks++;
    if (got.size() - n0 != want) begin
      errors++;
      $display("FAIL %s: got %0d acks required %0d", nm, got.size() - n0, want);
    end
  endtask

  task automatic b_chk(input string nm, input logic a, input logic bz, input logic [W-1:0] d);
    checks++;
    if (b_ack !== a || b_busy !== bz || b_dout !== d) begin
      errors++;
      $display("FAIL %s: ack/busy/data got %b/%b/%h required %b/%b/%h", nm, b_ack, b_busy, b_dout, a, bz, d);
    end
  endtask

  initial begin
    int n0, t;
    rst = 1'b1; aval = 1'b0; wr = 1'b0; addr = '0; din = '0;
    b_rst = 1'b1; b_aval = 1'b0; b_wr = 1'b0; b_addr = '0; b_din = '0;
    clear_from(0);
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0; b_rst = 1'b0;

    // Read of a never-written line: timing only.
    n0 = got.size();
    do_read(14'h0004, 0, 0);
    expect_count("read_unwritten_acks", n0, 4);

    wd = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    wg = '{0, 0, 0, 0};
    do_write(14'h0010);
    do_read(14'h0010, 0, 0);
    expect_words("write_read_0010", 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);

    wg = '{0, 0, 2, 0};
    do_write(14'h0012);
    do_read(14'h0010, 0, 0);
    expect_words("gap_write_0012", 32'h33333333, 32'h44444444, 32'h11111111, 32'h22222222);

    // Overlap during latency: dropped, flag sticky, burst still completes.
    do_read(14'h0010, 1, 0);
    expect_words("overlap_lat", 32'h33333333, 32'h44444444, 32'h11111111, 32'h22222222);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b required 1", err); end

    // Overlap on the edge that retires the burst.
    do_reset();
    do_read(14'h0010, RL + 4, 0);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_last_ack: got %b required 1", err); end

    do_reset();
    n0 = got.size();
    do_read(14'h0010, 0, RL + 2);
    expect_count("reset_mid_read_acks", n0, 2);
    do_read(14'h0010, 0, 0);
    expect_words("after_reset_read", 32'h33333333, 32'h44444444, 32'h11111111, 32'h22222222);

    for (int i = 0; i < 80; i++) begin
      logic [A-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? 14'($urandom) : 14'($urandom_range(0, 63));
      case ($urandom_range(0, 19))
        0: do_reset();
        1, 2, 3, 4, 5, 6, 7, 8: begin
          for (int k = 0; k < 4; k++) begin wd[k] = $urandom; wg[k] = $urandom_range(0, 2); end
          do_write(a);
        end
        default: do_read(a, ($urandom_range(0, 4) == 0) ? $urandom_range(1, RL + 4) : 0,
                         ($urandom_range(0, 19) == 0) ? $urandom_range(1, RL + 3) : 0);
      endcase
      for (int j = $urandom_range(0, 2); j > 0; j--) tick();
    end

    // Latency-1 instance: write wraps 0x3FFE->0x3FFD, read 0x3FFC returns line order.
    b_aval = 1'b1; b_wr = 1'b1; b_addr = 14'h3FFE; b_din = 32'hA0000001;
    tick();
    b_aval = 1'b0; b_din = 32'hA0000002; tick();
    b_din = 32'hA0000003; tick();
    b_din = 32'hA0000004; tick();
    b_wr = 1'b0;
    tick(); tick();
    b_chk("rl1_idle", 1'b0, 1'b0, 32'h0);
    b_aval = 1'b1; b_addr = 14'h3FFC;
    t = cyc + 1;
    tick();
    b_aval = 1'b0;
    b_chk("rl1_no_ack_at_T", 1'b0, 1'b1, 32'h0);
    tick(); b_chk("rl1_word0", 1'b1, 1'b1, 32'hA0000003);
    tick(); b_chk("rl1_word1", 1'b1, 1'b1, 32'hA0000004);
    tick(); b_chk("rl1_word2", 1'b1, 1'b1, 32'hA0000001);
    tick(); b_chk("rl1_word3", 1'b1, 1'b1, 32'hA0000002);
    tick(); b_chk("rl1_done", 1'b0, 1'b0, 32'h0);
    checks++;
    if (cyc != t + 5 || b_err !== 1'b0) begin
      errors++;
      $display("FAIL rl1_err_cycle: err %b cycle %0d required 0 at %0d", b_err, cyc, t + 5);
    end

    tick();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
